// File: rtl/gpr_dump_reader.sv
// Read-side dump engine for the general-purpose register file: walks a register
// range, streams each word over valid/ready and reports an XOR checksum and count.
module gpr_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31,
  parameter int SKIP_ZERO  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST_REG);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   rd_addr_next;
  logic                    out_valid_next;
  logic [DATA_WIDTH-1:0]   out_data_next;
  logic [ADDR_WIDTH-1:0]   out_index_next;
  logic [DATA_WIDTH-1:0]   checksum_next;
  logic [ADDR_WIDTH:0]     word_count_next;
  logic                    skip_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_addr    <= FIRST_ADDR;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      checksum   <= '0;
      word_count <= '0;
    end else begin
      state      <= state_next;
      rd_addr    <= rd_addr_next;
      out_valid  <= out_valid_next;
      out_data   <= out_data_next;
      out_index  <= out_index_next;
      checksum   <= checksum_next;
      word_count <= word_count_next;
    end
  end

  // The address only advances while below LAST_ADDR, so a range ending at the
  // top register never wraps back to index 0.
  always_comb begin
    state_next      = state;
    rd_addr_next    = rd_addr;
    out_valid_next  = out_valid;
    out_data_next   = out_data;
    out_index_next  = out_index;
    checksum_next   = checksum;
    word_count_next = word_count;
    skip_word       = (SKIP_ZERO != 0) && (rd_data == '0);

    case (state)
      IDLE: begin
        if (start) begin
          rd_addr_next    = FIRST_ADDR;
          checksum_next   = '0;
          word_count_next = '0;
          state_next      = READ;
        end
      end
      READ: begin
        if (skip_word) begin
          if (rd_addr == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            rd_addr_next = rd_addr + 1'b1;
          end
        end else begin
          out_data_next   = rd_data;
          out_index_next  = rd_addr;
          out_valid_next  = 1'b1;
          checksum_next   = checksum ^ rd_data;
          word_count_next = word_count + 1'b1;
          state_next      = HOLD;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_next = 1'b0;
          if (out_index == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            rd_addr_next = rd_addr + 1'b1;
            state_next   = READ;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Directed bench for gpr_dump_reader: full dump, backpressure, zero skipping,
// a short top-of-file range and reset in the middle of a dump.
module tb_gpr_dump_reader;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // dut0: full range, dut1: SKIP_ZERO, dut2: range 30..31
  logic        start0, start1, start2;
  logic        ready0, ready1, ready2;
  logic [4:0]  rd_addr0, rd_addr1, rd_addr2;
  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic        valid0, valid1, valid2;
  logic [31:0] data0, data1, data2;
  logic [4:0]  index0, index1, index2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [31:0] cs0, cs1, cs2;
  logic [5:0]  wc0, wc1, wc2;

  logic [31:0] regs0 [32];
  logic [31:0] regs1 [32];
  logic [31:0] regs2 [32];

  assign rd_data0 = regs0[rd_addr0];
  assign rd_data1 = regs1[rd_addr1];
  assign rd_data2 = regs2[rd_addr2];

  gpr_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .out_valid(valid0), .out_ready(ready0), .out_data(data0), .out_index(index0),
    .busy(busy0), .done(done0), .checksum(cs0), .word_count(wc0));

  gpr_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .out_valid(valid1), .out_ready(ready1), .out_data(data1), .out_index(index1),
    .busy(busy1), .done(done1), .checksum(cs1), .word_count(wc1));

  gpr_dump_reader #(.FIRST_REG(30), .LAST_REG(31), .SKIP_ZERO(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .out_valid(valid2), .out_ready(ready2), .out_data(data2), .out_index(index2),
    .busy(busy2), .done(done2), .checksum(cs2), .word_count(wc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fail_line(input string name, input longint got, input longint exp);
    failures++;
    $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (valid0 !== 1'b0) fail_line("reset_out_valid", valid0, 0);
    checks++; if (data0 !== 32'd0) fail_line("reset_out_data", data0, 0);
    checks++; if (index0 !== 5'd0) fail_line("reset_out_index", index0, 0);
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) fail_line("reset_busy_done", {busy0, done0}, 0);
    checks++; if (cs0 !== 32'd0 || wc0 !== 6'd0) fail_line("reset_cs_wc", {wc0, cs0}, 0);
    checks++; if (rd_addr0 !== 5'd0) fail_line("reset_rd_addr", rd_addr0, 0);
    checks++; if (rd_addr2 !== 5'd30) fail_line("reset_rd_addr_range", rd_addr2, 30);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    int n_words = 0, done_count = 0, cyc = 2, last_cyc = 0, bad_seq = 0, bad_gap = 0;
    logic [31:0] exp_cs = 32'd0;
    logic [31:0] got_cs = 32'd0;
    logic [5:0]  got_wc = 6'd0;
    for (int i = 0; i < 32; i++) begin
      regs0[i] = 32'(i * 3);
      exp_cs ^= 32'(i * 3);
    end
    ready0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++; if (busy0 !== 1'b1 || valid0 !== 1'b0) fail_line("full_first_cycle", {busy0, valid0}, 2'b10);
    @(negedge clk);
    checks++; if (valid0 !== 1'b1 || index0 !== 5'd0) fail_line("full_first_valid", {valid0, index0}, {1'b1, 5'd0});
    for (int c = 0; c < 150; c++) begin
      if (valid0 && ready0) begin
        if (index0 !== 5'(n_words) || data0 !== 32'(n_words * 3)) bad_seq++;
        if (n_words > 0 && cyc - last_cyc != 2) bad_gap++;
        last_cyc = cyc;
        n_words++;
      end
      if (done0) begin
        done_count++;
        got_cs = cs0;
        got_wc = wc0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (n_words != 32) fail_line("full_word_count_seen", n_words, 32);
    checks++; if (bad_seq != 0) fail_line("full_index_data", bad_seq, 0);
    checks++; if (bad_gap != 0) fail_line("full_two_cycle_rate", bad_gap, 0);
    checks++; if (done_count != 1) fail_line("full_done_pulses", done_count, 1);
    checks++; if (got_wc !== 6'd32) fail_line("full_word_count", got_wc, 32);
    checks++; if (got_cs !== exp_cs) fail_line("full_checksum", got_cs, exp_cs);
    checks++; if (cs0 !== exp_cs || wc0 !== 6'd32) fail_line("full_result_held", {wc0, cs0}, {6'd32, exp_cs});
  endtask

  task automatic test_backpressure();
    bit found = 0, stable = 1, seen_done = 0;
    ready0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (valid0 && index0 == 5'd4) found = 1;
    end
    ready0 = 1'b0;
    checks++; if (!found) fail_line("bp_reach_index4_timeout", 0, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (valid0 !== 1'b1 || index0 !== 5'd4 || data0 !== 32'd12) stable = 0;
    end
    checks++; if (!stable) fail_line("bp_stable_index4", {valid0, index0}, {1'b1, 5'd4});
    ready0 = 1'b1;
    @(negedge clk);
    checks++; if (valid0 !== 1'b0) fail_line("bp_accepted_once", valid0, 0);
    @(negedge clk);
    checks++; if (valid0 !== 1'b1 || index0 !== 5'd5 || data0 !== 32'd15)
      fail_line("bp_next_index5", {valid0, index0}, {1'b1, 5'd5});
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(negedge clk);
      if (done0) seen_done = 1;
    end
    checks++; if (!seen_done) fail_line("bp_done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic test_skip_zero();
    int n_words = 0, done_count = 0;
    logic [4:0]  idx [4];
    logic [31:0] dat [4];
    logic [31:0] got_cs = 32'd0;
    logic [5:0]  got_wc = 6'd0;
    for (int i = 0; i < 32; i++) regs1[i] = 32'd0;
    regs1[7]  = 32'hDEADBEEF;
    regs1[20] = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin idx[i] = '0; dat[i] = '0; end
    ready1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (valid1 && ready1) begin
        if (n_words < 4) begin idx[n_words] = index1; dat[n_words] = data1; end
        n_words++;
      end
      if (done1) begin
        done_count++;
        got_cs = cs1;
        got_wc = wc1;
      end
      @(negedge clk);
    end
    checks++; if (n_words != 2) fail_line("skip_words_seen", n_words, 2);
    checks++; if (idx[0] !== 5'd7 || dat[0] !== 32'hDEADBEEF) fail_line("skip_first_word", {idx[0], dat[0]}, {5'd7, 32'hDEADBEEF});
    checks++; if (idx[1] !== 5'd20 || dat[1] !== 32'h1) fail_line("skip_second_word", {idx[1], dat[1]}, {5'd20, 32'h1});
    checks++; if (done_count != 1) fail_line("skip_done_pulses", done_count, 1);
    checks++; if (got_wc !== 6'd2) fail_line("skip_word_count", got_wc, 2);
    checks++; if (got_cs !== 32'hDEADBEEE) fail_line("skip_checksum", got_cs, 32'hDEADBEEE);
  endtask

  task automatic test_range_and_start_ignore();
    int n_words = 0, done_count = 0, busy_after = 0;
    bit mid_pulsed = 0;
    logic [4:0]  idx [4];
    logic [31:0] got_cs = 32'd0;
    logic [5:0]  got_wc = 6'd0;
    for (int i = 0; i < 32; i++) regs2[i] = 32'h0000_1234;
    regs2[30] = 32'h0000_AAAA;
    regs2[31] = 32'h0000_5555;
    for (int i = 0; i < 4; i++) idx[i] = '0;
    ready2 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      start2 = 1'b0;
      if (done_count > 0 && busy2) busy_after++;
      if (valid2 && ready2) begin
        if (n_words < 4) idx[n_words] = index2;
        n_words++;
        if (!mid_pulsed) begin start2 = 1'b1; mid_pulsed = 1; end
      end
      if (done2) begin
        done_count++;
        got_cs = cs2;
        got_wc = wc2;
        start2 = 1'b1;
      end
      @(negedge clk);
    end
    start2 = 1'b0;
    checks++; if (n_words != 2) fail_line("range_words_seen", n_words, 2);
    checks++; if (idx[0] !== 5'd30 || idx[1] !== 5'd31) fail_line("range_indices", {idx[0], idx[1]}, {5'd30, 5'd31});
    checks++; if (done_count != 1) fail_line("range_done_pulses", done_count, 1);
    checks++; if (busy_after != 0) fail_line("range_start_in_done_ignored", busy_after, 0);
    checks++; if (got_wc !== 6'd2) fail_line("range_word_count", got_wc, 2);
    checks++; if (got_cs !== 32'h0000_FFFF) fail_line("range_checksum", got_cs, 32'h0000_FFFF);
  endtask

  task automatic test_reset_mid_dump();
    bit found = 0, seen_done = 0;
    int done_count = 0, busy_count = 0;
    ready0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (valid0 && index0 == 5'd10) found = 1;
    end
    checks++; if (!found) fail_line("rst_reach_index10_timeout", 0, 1);
    ready0 = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0)
      fail_line("rst_abort_outputs", {valid0, busy0, done0}, 0);
    checks++; if (rd_addr0 !== 5'd0 || wc0 !== 6'd0 || cs0 !== 32'd0)
      fail_line("rst_abort_state", {rd_addr0, wc0}, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done0) done_count++;
      if (busy0 || valid0) busy_count++;
    end
    checks++; if (done_count != 0 || busy_count != 0) fail_line("rst_no_done_after_abort", {done_count, busy_count}, 0);
    ready0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    checks++; if (valid0 !== 1'b1 || index0 !== 5'd0 || data0 !== 32'd0)
      fail_line("rst_restart_first_word", {valid0, index0}, {1'b1, 5'd0});
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(negedge clk);
      if (done0) seen_done = 1;
    end
    checks++; if (!seen_done || wc0 !== 6'd32) fail_line("rst_restart_done", {seen_done, wc0}, {1'b1, 6'd32});
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs0[i] = 32'd0; regs1[i] = 32'd0; regs2[i] = 32'd0;
    end
    test_reset();
    test_full_dump();
    test_backpressure();
    test_skip_zero();
    test_range_and_start_ignore();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
